// File: rtl/gray_marker_pipe.sv
// rtl/gray_marker_pipe.sv - pipelined RGB-to-luma converter with frame-stable marker overlay
//
// Purpose: converts one RGB pixel per clock to luma with a fixed 3-cycle latency.
// Depending on the mode, it outputs passthrough, grayscale or a binary threshold
// image, and it can overlay a square detection marker. Mode, threshold and marker
// position are sampled once per frame on iFrameStart, so the overlay cannot tear
// mid-frame.
//
// Ports:
//   iCLK, iRST                 clock, asynchronous active-high reset
//   iDVAL                      input pixel valid
//   iRed/iGreen/iBlue          input colour channels (DW bits)
//   iXposition/iYposition      coordinates of the input pixel (PW bits)
//   iXresult/iYresult          detected object top-left corner (PW bits)
//   iFinished                  detection result valid
//   iFrameStart                one-cycle pulse before the first pixel of a frame
//   iMode                      0 pass, 1 gray, 2 threshold, 3 gray without marker
//   iThresh                    threshold for mode 2
//   oDVAL                      output valid (iDVAL delayed by 3)
//   oRed/oGreen/oBlue          output colour channels
module gray_marker_pipe #(
  parameter int DW     = 10,
  parameter int PW     = 13,
  parameter int SQUARE = 5,
  parameter int WR     = 77,
  parameter int WG     = 150,
  parameter int WB     = 29,
  parameter logic [DW-1:0] MARK_R = '1,
  parameter logic [DW-1:0] MARK_G = '0,
  parameter logic [DW-1:0] MARK_B = '0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [PW-1:0] iXposition,
  input  logic [PW-1:0] iYposition,
  input  logic [PW-1:0] iXresult,
  input  logic [PW-1:0] iYresult,
  input  logic          iFinished,
  input  logic          iFrameStart,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iThresh,
  output logic          oDVAL,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue
);

  localparam int PRW = DW + 8;
  localparam logic [PRW-1:0] WR_L = PRW'(WR);
  localparam logic [PRW-1:0] WG_L = PRW'(WG);
  localparam logic [PRW-1:0] WB_L = PRW'(WB);
  localparam logic [DW-1:0]  MAXV = '1;

  // Frame shadow registers; the _d values double as the effective settings so a
  // pixel arriving together with iFrameStart already sees the new frame's values.
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] thresh_q, thresh_d;
  logic [PW-1:0] xs_q, xs_d, ys_q, ys_d;
  logic          fin_q, fin_d;

  always_comb begin
    mode_d   = mode_q;
    thresh_d = thresh_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    fin_d    = fin_q;
    if (iFrameStart) begin
      mode_d   = iMode;
      thresh_d = iThresh;
      xs_d     = iXresult;
      ys_d     = iYresult;
      fin_d    = iFinished;
    end
  end

  // Stage 1: products, raw colour, marker hit. Mode and threshold travel with
  // the pixel so pixels still in flight at a frame boundary keep their frame's mode.
  logic [PRW-1:0] pr_q, pg_q, pb_q;
  logic [DW-1:0]  r1_q, g1_q, b1_q, thresh1_q;
  logic [1:0]     mode1_q;
  logic           hit1_q, v1_q;
  logic [PW:0]    x_hi, y_hi;
  logic           hit_d;

  // Upper bounds are one bit wider so a box near the right/bottom edge clips
  // instead of wrapping around to column/row 0.
  assign x_hi  = {1'b0, xs_d} + (PW+1)'(SQUARE - 1);
  assign y_hi  = {1'b0, ys_d} + (PW+1)'(SQUARE - 1);
  assign hit_d = fin_d
               && (iXposition >= xs_d) && ({1'b0, iXposition} <= x_hi)
               && (iYposition >= ys_d) && ({1'b0, iYposition} <= y_hi);

  // Stage 2: luma sum, truncate, saturate.
  logic [PRW+1:0] sum;
  logic [DW+1:0]  gray_full;
  logic [DW-1:0]  gray_d;
  logic [DW-1:0]  gray2_q, r2_q, g2_q, b2_q, thresh2_q;
  logic [1:0]     mode2_q;
  logic           hit2_q, v2_q;

  assign sum       = {2'b00, pr_q} + {2'b00, pg_q} + {2'b00, pb_q};
  assign gray_full = (DW+2)'(sum >> 8);
  assign gray_d    = (gray_full > (DW+2)'(MAXV)) ? MAXV : gray_full[DW-1:0];

  // Stage 3: output select.
  logic [DW-1:0] or_q, og_q, ob_q, or_d, og_d, ob_d;
  logic          v3_q;

  always_comb begin
    or_d = r2_q;
    og_d = g2_q;
    ob_d = b2_q;
    case (mode2_q)
      2'd1, 2'd3: begin
        or_d = gray2_q;
        og_d = gray2_q;
        ob_d = gray2_q;
      end
      2'd2: begin
        or_d = (gray2_q >= thresh2_q) ? MAXV : '0;
        og_d = or_d;
        ob_d = or_d;
      end
      default: ;
    endcase
    if (hit2_q && (mode2_q != 2'd3)) begin
      or_d = MARK_R;
      og_d = MARK_G;
      ob_d = MARK_B;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_q <= '0; thresh_q <= '0; xs_q <= '0; ys_q <= '0; fin_q <= 1'b0;
      pr_q <= '0; pg_q <= '0; pb_q <= '0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0; thresh1_q <= '0;
      mode1_q <= '0; hit1_q <= 1'b0; v1_q <= 1'b0;
      gray2_q <= '0; r2_q <= '0; g2_q <= '0; b2_q <= '0; thresh2_q <= '0;
      mode2_q <= '0; hit2_q <= 1'b0; v2_q <= 1'b0;
      or_q <= '0; og_q <= '0; ob_q <= '0; v3_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      fin_q    <= fin_d;
      v1_q     <= iDVAL;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      if (iDVAL) begin
        pr_q      <= {8'd0, iRed} * WR_L;
        pg_q      <= {8'd0, iGreen} * WG_L;
        pb_q      <= {8'd0, iBlue} * WB_L;
        r1_q      <= iRed;
        g1_q      <= iGreen;
        b1_q      <= iBlue;
        hit1_q    <= hit_d;
        mode1_q   <= mode_d;
        thresh1_q <= thresh_d;
      end
      if (v1_q) begin
        gray2_q   <= gray_d;
        r2_q      <= r1_q;
        g2_q      <= g1_q;
        b2_q      <= b1_q;
        hit2_q    <= hit1_q;
        mode2_q   <= mode1_q;
        thresh2_q <= thresh1_q;
      end
      if (v2_q) begin
        or_q <= or_d;
        og_q <= og_d;
        ob_q <= ob_d;
      end
    end
  end

  assign oDVAL  = v3_q;
  assign oRed   = or_q;
  assign oGreen = og_q;
  assign oBlue  = ob_q;

endmodule

// File: tb/tb_gray_marker_pipe.sv
// tb/tb_gray_marker_pipe.sv - directed self-checking bench for gray_marker_pipe
module tb_gray_marker_pipe;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iDVAL = 1'b0;
  logic [9:0]  iRed = '0, iGreen = '0, iBlue = '0, iThresh = '0;
  logic [12:0] iXposition = '0, iYposition = '0, iXresult = '0, iYresult = '0;
  logic        iFinished = 1'b0, iFrameStart = 1'b0;
  logic [1:0]  iMode = '0;
  logic        oDVAL;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [30:0] got;
  int          nchk = 0;
  int          nerr = 0;

  gray_marker_pipe dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iXposition(iXposition), .iYposition(iYposition),
    .iXresult(iXresult), .iYresult(iYresult),
    .iFinished(iFinished), .iFrameStart(iFrameStart),
    .iMode(iMode), .iThresh(iThresh),
    .oDVAL(oDVAL), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue)
  );

  always #5 iCLK = ~iCLK;
  assign got = {oDVAL, oRed, oGreen, oBlue};

  task automatic frame(input logic [1:0] m, input logic [9:0] th,
                       input logic [12:0] xr, input logic [12:0] yr, input logic fin);
    iMode = m; iThresh = th; iXresult = xr; iYresult = yr; iFinished = fin;
    iFrameStart = 1'b1;
    @(negedge iCLK);
    iFrameStart = 1'b0;
  endtask

  // Drives one pixel for one cycle and returns at the negedge where it is on the output.
  task automatic pix(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                     input logic [12:0] x, input logic [12:0] y, input logic fs);
    iRed = r; iGreen = g; iBlue = b; iXposition = x; iYposition = y;
    iDVAL = 1'b1; iFrameStart = fs;
    @(negedge iCLK);
    iDVAL = 1'b0; iFrameStart = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge iCLK);
    nchk++; if (got !== 31'd0) begin nerr++; $display("FAIL reset_held: got v=%0d rgb=%0d/%0d/%0d exp 0/0/0/0", oDVAL, oRed, oGreen, oBlue); end
    iRST = 1'b0;
    @(negedge iCLK);
    nchk++; if (got !== 31'd0) begin nerr++; $display("FAIL reset_release: got v=%0d rgb=%0d/%0d/%0d exp 0/0/0/0", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_gray;
    frame(2'd1, 10'd0, 13'd0, 13'd0, 1'b0);
    iRed = 10'd1023; iGreen = 10'd1023; iBlue = 10'd1023; iDVAL = 1'b1;
    @(negedge iCLK);
    iDVAL = 1'b0;
    nchk++; if (oDVAL !== 1'b0) begin nerr++; $display("FAIL lat_t1: got %0d exp 0", oDVAL); end
    @(negedge iCLK);
    nchk++; if (oDVAL !== 1'b0) begin nerr++; $display("FAIL lat_t2: got %0d exp 0", oDVAL); end
    @(negedge iCLK);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd1023, 10'd1023}) begin nerr++; $display("FAIL gray_white: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/1023/1023", oDVAL, oRed, oGreen, oBlue); end
    @(negedge iCLK);
    nchk++; if (got !== {1'b0, 10'd1023, 10'd1023, 10'd1023}) begin nerr++; $display("FAIL gray_hold: got v=%0d rgb=%0d/%0d/%0d exp 0/1023/1023/1023", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL gray_red: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd0, 10'd1023, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd599, 10'd599, 10'd599}) begin nerr++; $display("FAIL gray_green: got v=%0d rgb=%0d/%0d/%0d exp 1/599/599/599", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd0, 10'd0, 10'd1023, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd115, 10'd115, 10'd115}) begin nerr++; $display("FAIL gray_blue: got v=%0d rgb=%0d/%0d/%0d exp 1/115/115/115", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd100, 10'd200, 10'd300, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd181, 10'd181, 10'd181}) begin nerr++; $display("FAIL gray_mix: got v=%0d rgb=%0d/%0d/%0d exp 1/181/181/181", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_passthrough;
    frame(2'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    pix(10'd100, 10'd200, 10'd300, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd100, 10'd200, 10'd300}) begin nerr++; $display("FAIL pass: got v=%0d rgb=%0d/%0d/%0d exp 1/100/200/300", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_threshold;
    frame(2'd2, 10'd300, 13'd0, 13'd0, 1'b0);
    pix(10'd1023, 10'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd1023, 10'd1023}) begin nerr++; $display("FAIL thr_300: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/1023/1023", oDVAL, oRed, oGreen, oBlue); end
    frame(2'd2, 10'd308, 13'd0, 13'd0, 1'b0);
    pix(10'd1023, 10'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd0, 10'd0, 10'd0}) begin nerr++; $display("FAIL thr_308: got v=%0d rgb=%0d/%0d/%0d exp 1/0/0/0", oDVAL, oRed, oGreen, oBlue); end
    frame(2'd2, 10'd307, 13'd0, 13'd0, 1'b0);
    pix(10'd1023, 10'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd1023, 10'd1023}) begin nerr++; $display("FAIL thr_eq: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/1023/1023", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_marker;
    frame(2'd1, 10'd0, 13'd100, 13'd50, 1'b1);
    pix(10'd1023, 10'd0, 10'd0, 13'd104, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL mk_in: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd105, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL mk_xout: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd99, 13'd50, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL mk_xlow: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd100, 13'd50, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL mk_corner: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd104, 13'd55, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL mk_yout: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    frame(2'd3, 10'd0, 13'd100, 13'd50, 1'b1);
    pix(10'd1023, 10'd0, 10'd0, 13'd104, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL mk_mode3: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    frame(2'd0, 10'd0, 13'd100, 13'd50, 1'b1);
    pix(10'd100, 10'd200, 10'd300, 13'd102, 13'd52, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL mk_mode0: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    frame(2'd1, 10'd0, 13'd100, 13'd50, 1'b0);
    pix(10'd1023, 10'd0, 10'd0, 13'd104, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL mk_nofin: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_shadow;
    frame(2'd1, 10'd0, 13'd100, 13'd50, 1'b1);
    iXresult = 13'd200; iMode = 2'd0;
    pix(10'd1023, 10'd0, 10'd0, 13'd104, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL sh_oldmk: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd300, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL sh_oldmode: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd100, 10'd200, 10'd300, 13'd204, 13'd54, 1'b1);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL sh_samecyc: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd100, 10'd200, 10'd300, 13'd104, 13'd54, 1'b0);
    nchk++; if (got !== {1'b1, 10'd100, 10'd200, 10'd300}) begin nerr++; $display("FAIL sh_newmode: got v=%0d rgb=%0d/%0d/%0d exp 1/100/200/300", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_edge_clip;
    frame(2'd1, 10'd0, 13'd8190, 13'd0, 1'b1);
    pix(10'd1023, 10'd0, 10'd0, 13'd8190, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL edge_8190: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd8191, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL edge_8191: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL edge_wrap0: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd8191, 13'd4, 1'b0);
    nchk++; if (got !== {1'b1, 10'd1023, 10'd0, 10'd0}) begin nerr++; $display("FAIL edge_y4: got v=%0d rgb=%0d/%0d/%0d exp 1/1023/0/0", oDVAL, oRed, oGreen, oBlue); end
    pix(10'd1023, 10'd0, 10'd0, 13'd8191, 13'd5, 1'b0);
    nchk++; if (got !== {1'b1, 10'd307, 10'd307, 10'd307}) begin nerr++; $display("FAIL edge_y5: got v=%0d rgb=%0d/%0d/%0d exp 1/307/307/307", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_gap;
    frame(2'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    iRed = 10'd11; iGreen = 10'd22; iBlue = 10'd33; iDVAL = 1'b1;
    @(negedge iCLK);
    iDVAL = 1'b0;
    @(negedge iCLK);
    nchk++; if (oDVAL !== 1'b0) begin nerr++; $display("FAIL gap_empty: got %0d exp 0", oDVAL); end
    iRed = 10'd44; iGreen = 10'd55; iBlue = 10'd66; iDVAL = 1'b1;
    @(negedge iCLK);
    iDVAL = 1'b0;
    nchk++; if (got !== {1'b1, 10'd11, 10'd22, 10'd33}) begin nerr++; $display("FAIL gap_a: got v=%0d rgb=%0d/%0d/%0d exp 1/11/22/33", oDVAL, oRed, oGreen, oBlue); end
    @(negedge iCLK);
    nchk++; if (got !== {1'b0, 10'd11, 10'd22, 10'd33}) begin nerr++; $display("FAIL gap_hold: got v=%0d rgb=%0d/%0d/%0d exp 0/11/22/33", oDVAL, oRed, oGreen, oBlue); end
    @(negedge iCLK);
    nchk++; if (got !== {1'b1, 10'd44, 10'd55, 10'd66}) begin nerr++; $display("FAIL gap_b: got v=%0d rgb=%0d/%0d/%0d exp 1/44/55/66", oDVAL, oRed, oGreen, oBlue); end
    @(negedge iCLK);
    nchk++; if (got !== {1'b0, 10'd44, 10'd55, 10'd66}) begin nerr++; $display("FAIL gap_bhold: got v=%0d rgb=%0d/%0d/%0d exp 0/44/55/66", oDVAL, oRed, oGreen, oBlue); end
  endtask

  task automatic test_reset_midstream;
    logic exp_v;
    frame(2'd0, 10'd0, 13'd0, 13'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      exp_v = (k >= 3 && k <= 5) || (k >= 9);
      nchk++; if (oDVAL !== exp_v) begin nerr++; $display("FAIL rst_v%0d: got %0d exp %0d", k, oDVAL, exp_v); end
      if (k == 5) begin
        nchk++; if (got !== {1'b1, 10'd21, 10'd22, 10'd23}) begin nerr++; $display("FAIL rst_pre: got v=%0d rgb=%0d/%0d/%0d exp 1/21/22/23", oDVAL, oRed, oGreen, oBlue); end
        iRST = 1'b1;
        #1;
        nchk++; if (got !== 31'd0) begin nerr++; $display("FAIL rst_async: got v=%0d rgb=%0d/%0d/%0d exp 0/0/0/0", oDVAL, oRed, oGreen, oBlue); end
      end
      if (k == 6) iRST = 1'b0;
      if (k == 9) begin
        nchk++; if (got !== {1'b1, 10'd61, 10'd62, 10'd63}) begin nerr++; $display("FAIL rst_first: got v=%0d rgb=%0d/%0d/%0d exp 1/61/62/63", oDVAL, oRed, oGreen, oBlue); end
      end
      iRed = 10'(10 * k + 1); iGreen = 10'(10 * k + 2); iBlue = 10'(10 * k + 3);
      iDVAL = 1'b1;
      @(negedge iCLK);
    end
    iDVAL = 1'b0;
    nchk++; if (got !== {1'b1, 10'd71, 10'd72, 10'd73}) begin nerr++; $display("FAIL rst_next: got v=%0d rgb=%0d/%0d/%0d exp 1/71/72/73", oDVAL, oRed, oGreen, oBlue); end
    repeat (4) @(negedge iCLK);
  endtask

  initial begin
    test_reset();
    test_gray();
    test_passthrough();
    test_threshold();
    test_marker();
    test_shadow();
    test_edge_clip();
    test_gap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
